// File: rtl/axi_ddc_cfg_pkg.sv
// -----------------------------------------------------------------------------
// axi_ddc_cfg_pkg
// Shared definitions for the DDC configuration AXI4-Lite initiator:
//   - state_t       : transaction sequencer states
//   - RESP_*        : AXI4-Lite BRESP/RRESP encodings
//   - DDC_REG_*     : byte offsets of the DDC core's register map
//   - resp_is_err() : any response other than OKAY is reported as an error
// -----------------------------------------------------------------------------
package axi_ddc_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,   // AW and W channels in flight
        ST_WR_B  = 3'd2,   // waiting for the write response
        ST_RD_AR = 3'd3,   // AR channel in flight
        ST_RD_R  = 3'd4,   // waiting for read data
        ST_RSP   = 3'd5    // one-cycle completion strobe
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [4:0] DDC_REG_00 = 5'h00;
    localparam logic [4:0] DDC_REG_04 = 5'h04;
    localparam logic [4:0] DDC_REG_08 = 5'h08;
    localparam logic [4:0] DDC_REG_0C = 5'h0C;
    localparam logic [4:0] DDC_REG_10 = 5'h10;
    localparam logic [4:0] DDC_REG_14 = 5'h14;
    localparam logic [4:0] DDC_REG_18 = 5'h18;
    localparam logic [4:0] DDC_REG_1C = 5'h1C;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_ddc_cfg_master.sv
// -----------------------------------------------------------------------------
// axi_ddc_cfg_master
// AXI4-Lite initiator that turns single-word commands into one AXI read or
// write on the DDC core's register port and reports the outcome.
//
// Ports:
//   m00_axi_aclk / m00_axi_aresetn : clock, asynchronous active-low reset
//   cmd_*   : command request (valid/ready, write flag, byte address, data)
//   rsp_*   : one-cycle completion strobe with read data, response, error
//   m00_axi_* : AXI4-Lite master channels AW, W, B, AR, R (all registered)
//
// Build option:
//   AXI_DDC_CFG_VERIFY_EN - every write is followed by a read-back of the same
//   address; the response carries the read-back data and flags an error on a
//   non-OKAY response or a data mismatch.
// -----------------------------------------------------------------------------
module axi_ddc_cfg_master
    import axi_ddc_cfg_pkg::*;
#(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 5
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_aresetn,

    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,

    output logic                                rsp_valid,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic                                rsp_err,

    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                          m00_axi_awprot,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                          m00_axi_arprot,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);

    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam int AW = C_M00_AXI_ADDR_WIDTH;

    // Registers are word-wide, so the two byte-lane address bits are cleared.
    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};

    state_t state, next_state;

    logic          awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
    logic          awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt, rsp_valid_nxt;
    logic          accept;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          wr_chans_done;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    resp_q;
    logic          err_q;
`ifdef AXI_DDC_CFG_VERIFY_EN
    logic          is_write_q;
`endif

    assign aw_hs = awvalid_q & m00_axi_awready;
    assign w_hs  = wvalid_q  & m00_axi_wready;
    assign b_hs  = bready_q  & m00_axi_bvalid;
    assign ar_hs = arvalid_q & m00_axi_arready;
    assign r_hs  = rready_q  & m00_axi_rvalid;

    // AW and W complete independently; the write phase ends once neither is
    // still pending after this cycle.
    assign wr_chans_done = (~awvalid_q | m00_axi_awready) & (~wvalid_q | m00_axi_wready);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (cmd_valid) next_state = cmd_write ? ST_WR : ST_RD_AR;
            ST_WR:    if (wr_chans_done) next_state = ST_WR_B;
`ifdef AXI_DDC_CFG_VERIFY_EN
            ST_WR_B:  if (b_hs) next_state = ST_RD_AR;
`else
            ST_WR_B:  if (b_hs) next_state = ST_RSP;
`endif
            ST_RD_AR: if (ar_hs) next_state = ST_RD_R;
            ST_RD_R:  if (r_hs) next_state = ST_RSP;
            ST_RSP:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: command handshake and next values of the registered
    // AXI controls. A valid is raised on entry to its phase and cleared only
    // by its own handshake, so it never depends on ready.
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready     = (state == ST_IDLE);
        accept        = cmd_ready & cmd_valid;
        awvalid_nxt   = (accept & cmd_write) | (awvalid_q & ~m00_axi_awready);
        wvalid_nxt    = (accept & cmd_write) | (wvalid_q  & ~m00_axi_wready);
        bready_nxt    = ((state == ST_WR) & wr_chans_done) | (bready_q & ~m00_axi_bvalid);
        arvalid_nxt   = ((state != ST_RD_AR) & (next_state == ST_RD_AR))
                      | (arvalid_q & ~m00_axi_arready);
        rready_nxt    = ar_hs | (rready_q & ~m00_axi_rvalid);
        rsp_valid_nxt = (next_state == ST_RSP);
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            awvalid_q   <= awvalid_nxt;
            wvalid_q    <= wvalid_nxt;
            bready_q    <= bready_nxt;
            arvalid_q   <= arvalid_nxt;
            rready_q    <= rready_nxt;
            rsp_valid_q <= rsp_valid_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Command latch and response capture
    // -------------------------------------------------------------------------
    // NOTE: the data registers are reset as well, so the AXI address/data
    // buses and the response fields read as zero straight out of reset.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            resp_q     <= RESP_OKAY;
            err_q      <= 1'b0;
`ifdef AXI_DDC_CFG_VERIFY_EN
            is_write_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q     <= cmd_addr & ALIGN_MASK;
                wdata_q    <= cmd_wdata;
                rdata_q    <= '0;
                resp_q     <= RESP_OKAY;
                err_q      <= 1'b0;
`ifdef AXI_DDC_CFG_VERIFY_EN
                is_write_q <= cmd_write;
`endif
            end
            if (b_hs) begin
                resp_q <= m00_axi_bresp;
                err_q  <= resp_is_err(m00_axi_bresp);
            end
            if (r_hs) begin
                rdata_q <= m00_axi_rdata;
                // A failing write response takes precedence over the read-back one.
                if (!resp_is_err(resp_q)) begin
                    resp_q <= m00_axi_rresp;
                end
`ifdef AXI_DDC_CFG_VERIFY_EN
                err_q <= err_q | resp_is_err(m00_axi_rresp)
                       | (is_write_q & (m00_axi_rdata != wdata_q));
`else
                err_q <= err_q | resp_is_err(m00_axi_rresp);
`endif
            end
        end
    end

    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = '1;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_axi_ddc_cfg_master.sv
// -----------------------------------------------------------------------------
// tb_axi_ddc_cfg_master
// Self-checking bench for axi_ddc_cfg_master: a directed vector table, a
// mid-transaction reset sequence and randomized commands, all run against a
// cycle-level AXI4-Lite slave with programmable per-channel wait states.
// Expected results come from a register-map model and timing arithmetic.
// Honours AXI_DDC_CFG_VERIFY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_axi_ddc_cfg_master;
    import axi_ddc_cfg_pkg::*;

`ifdef AXI_DDC_CFG_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] slave_mem [8];
    logic [31:0] ref_mem   [8];

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  bresp, rresp;
        bit          corrupt;     // slave flips bit 0 of read data
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        bit          exp_err;
        int          exp_lat;     // cycles from acceptance to rsp_valid
    } vec_t;

    always #5 clk = ~clk;

    axi_ddc_cfg_master dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_resp        (rsp_resp),
        .rsp_err         (rsp_err),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awprot  (awprot),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(bit wr, logic [4:0] addr, logic [31:0] wd,
                                int aw_d, int w_d, int b_d, int ar_d, int r_d,
                                logic [1:0] br, logic [1:0] rr, bit corrupt,
                                logic [31:0] exp_rdata, logic [1:0] exp_resp,
                                bit exp_err, int exp_lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wd;
        v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
        v.bresp = br; v.rresp = rr; v.corrupt = corrupt;
        v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_err = exp_err;
        v.exp_lat = exp_lat;
        return v;
    endfunction

    // Reference model: outcome and latency of one command from the register
    // map contents and the slave's wait states.
    function automatic void predict(inout vec_t v);
        logic [31:0] rb;
        int          wr_wait;
        wr_wait = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
        if (v.wr) begin
            if (VERIFY) begin
                rb          = v.wdata ^ {31'b0, v.corrupt};
                v.exp_rdata = rb;
                v.exp_resp  = (v.bresp != RESP_OKAY) ? v.bresp : v.rresp;
                v.exp_err   = (v.bresp != RESP_OKAY) || (v.rresp != RESP_OKAY) || (rb != v.wdata);
                v.exp_lat   = 5 + wr_wait + v.b_d + v.ar_d + v.r_d;
            end else begin
                v.exp_rdata = '0;
                v.exp_resp  = v.bresp;
                v.exp_err   = (v.bresp != RESP_OKAY);
                v.exp_lat   = 3 + wr_wait + v.b_d;
            end
        end else begin
            v.exp_rdata = ref_mem[v.addr[4:2]] ^ {31'b0, v.corrupt};
            v.exp_resp  = v.rresp;
            v.exp_err   = (v.rresp != RESP_OKAY);
            v.exp_lat   = 3 + v.ar_d + v.r_d;
        end
    endfunction

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        bresp = '0; rresp = '0; rdata = '0;
    endtask

    // Issue one command and play the slave until one cycle past rsp_valid.
    // Cycle 1 is the cycle after acceptance; everything is sampled on negedge.
    task automatic run_cmd(input vec_t v, input string tag);
        int          guard, c, lat, rsp_cnt, busy_ready, early_bready;
        int          aw_cnt, w_cnt, ar_cnt;
        int          aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc;
        int          wr_done_cycle, ar_cycle;
        bit          aw_done, w_done, b_done, ar_done, r_done, exp_ar;
        logic [4:0]  rec_awaddr, rec_araddr, eff_addr;
        logic [31:0] rec_wdata, cap_rdata;
        logic [3:0]  rec_wstrb;
        logic [2:0]  rec_awprot, rec_arprot;
        logic [1:0]  cap_resp;
        logic        cap_err;

        lat = -1; rsp_cnt = 0; busy_ready = 0; early_bready = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_cyc = 0; w_cyc = 0; b_cyc = 0; ar_cyc = 0; r_cyc = 0;
        wr_done_cycle = -1; ar_cycle = -1;
        aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
        rec_awaddr = '0; rec_araddr = '0; rec_wdata = '0; rec_wstrb = '0;
        rec_awprot = '0; rec_arprot = '0;
        cap_rdata = '0; cap_resp = '0; cap_err = 1'b0;
        eff_addr = v.addr & 5'h1C;
        exp_ar   = !v.wr || VERIFY;

        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".cmd_ready"}, cmd_ready, 1);

        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 5'($urandom); cmd_wdata = $urandom;

        for (c = 1; c <= 100; c++) begin
            if (rsp_valid) begin
                rsp_cnt++;
                if (lat < 0) begin
                    lat = c; cap_rdata = rsp_rdata; cap_resp = rsp_resp; cap_err = rsp_err;
                end
            end
            if (lat > 0 && c == lat + 1) begin
                check({tag, ".ready_after_rsp"}, cmd_ready, 1);
                break;
            end
            if (cmd_ready) busy_ready++;
            if (awvalid) aw_cyc++;
            if (wvalid)  w_cyc++;
            if (bready)  b_cyc++;
            if (arvalid) ar_cyc++;
            if (rready)  r_cyc++;
            if (bready && !(aw_done && w_done)) early_bready++;

            // Slave drive for this cycle; handshakes complete at the next posedge.
            slave_idle();
            bresp = 2'($urandom);
            rdata = $urandom;
            if (!b_done && wr_done_cycle >= 0 && c > wr_done_cycle + v.b_d) begin
                bvalid = 1'b1; bresp = v.bresp;
                if (bready) begin
                    b_done = 1;
                    slave_mem[rec_awaddr[4:2]] = rec_wdata;
                end
            end
            if (awvalid && !aw_done) begin
                if (aw_cnt >= v.aw_d) begin
                    awready = 1'b1; aw_done = 1; rec_awaddr = awaddr; rec_awprot = awprot;
                end else aw_cnt++;
            end
            if (wvalid && !w_done) begin
                if (w_cnt >= v.w_d) begin
                    wready = 1'b1; w_done = 1; rec_wdata = wdata; rec_wstrb = wstrb;
                end else w_cnt++;
            end
            if (aw_done && w_done && wr_done_cycle < 0) wr_done_cycle = c;
            if (ar_done && !r_done && c > ar_cycle + v.r_d) begin
                rvalid = 1'b1; rresp = v.rresp;
                rdata  = slave_mem[rec_araddr[4:2]] ^ {31'b0, v.corrupt};
                if (rready) r_done = 1;
            end
            if (arvalid && !ar_done) begin
                if (ar_cnt >= v.ar_d) begin
                    arready = 1'b1; ar_done = 1; ar_cycle = c; rec_araddr = araddr; rec_arprot = arprot;
                end else ar_cnt++;
            end
            @(negedge clk);
        end
        slave_idle();

        check({tag, ".rsp_count"},    rsp_cnt, 1);
        check({tag, ".latency"},      lat, v.exp_lat);
        check({tag, ".rsp_rdata"},    cap_rdata, v.exp_rdata);
        check({tag, ".rsp_resp"},     cap_resp, v.exp_resp);
        check({tag, ".rsp_err"},      cap_err, v.exp_err);
        check({tag, ".busy_ready"},   busy_ready, 0);
        check({tag, ".early_bready"}, early_bready, 0);
        check({tag, ".aw_cycles"},    aw_cyc, v.wr ? v.aw_d + 1 : 0);
        check({tag, ".w_cycles"},     w_cyc,  v.wr ? v.w_d + 1 : 0);
        check({tag, ".b_cycles"},     b_cyc,  v.wr ? v.b_d + 1 : 0);
        check({tag, ".ar_cycles"},    ar_cyc, exp_ar ? v.ar_d + 1 : 0);
        check({tag, ".r_cycles"},     r_cyc,  exp_ar ? v.r_d + 1 : 0);
        if (aw_done) begin
            check({tag, ".awaddr"}, rec_awaddr, eff_addr);
            check({tag, ".awprot"}, rec_awprot, 0);
        end
        if (w_done) begin
            check({tag, ".wdata"}, rec_wdata, v.wdata);
            check({tag, ".wstrb"}, rec_wstrb, 4'hF);
        end
        if (ar_done) begin
            check({tag, ".araddr"}, rec_araddr, eff_addr);
            check({tag, ".arprot"}, rec_arprot, 0);
        end
        if (v.wr) ref_mem[v.addr[4:2]] = v.wdata;
    endtask

    initial begin
        vec_t tbl [11];
        vec_t v;
        int   rst_rsp;

        foreach (slave_mem[i]) begin
            slave_mem[i] = '0;
            ref_mem[i]   = '0;
        end

        //               wr addr                 wdata         aw w  b  ar r  bresp        rresp        cor exp_rdata                             resp         err  lat
        tbl[0]  = mk(1, DDC_REG_04,         32'hDEADBEEF, 0, 0, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   0, VERIFY ? 32'hDEADBEEF : 32'h0, RESP_OKAY,   0, VERIFY ? 5 : 3);
        tbl[1]  = mk(1, DDC_REG_08,         32'h12345678, 0, 0, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   0, VERIFY ? 32'h12345678 : 32'h0, RESP_OKAY,   0, VERIFY ? 5 : 3);
        tbl[2]  = mk(0, DDC_REG_08,         32'h0,        0, 0, 0, 0, 4, RESP_OKAY,   RESP_OKAY,   0, 32'h12345678,                  RESP_OKAY,   0, 7);
        tbl[3]  = mk(1, DDC_REG_10,         32'h0BADF00D, 0, 3, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   0, VERIFY ? 32'h0BADF00D : 32'h0, RESP_OKAY,   0, VERIFY ? 8 : 6);
        tbl[4]  = mk(0, DDC_REG_08,         32'h0,        0, 0, 0, 0, 0, RESP_OKAY,   RESP_SLVERR, 0, 32'h12345678,                  RESP_SLVERR, 1, 3);
        tbl[5]  = mk(1, DDC_REG_0C,         32'hA5A5A5A5, 0, 0, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   1, VERIFY ? 32'hA5A5A5A4 : 32'h0, RESP_OKAY,   VERIFY, VERIFY ? 5 : 3);
        tbl[6]  = mk(1, DDC_REG_14 | 5'h3,  32'hCAFEF00D, 0, 0, 2, 0, 0, RESP_SLVERR, RESP_OKAY,   0, VERIFY ? 32'hCAFEF00D : 32'h0, RESP_SLVERR, 1, VERIFY ? 7 : 5);
        tbl[7]  = mk(0, DDC_REG_14 | 5'h2,  32'h0,        0, 0, 0, 2, 0, RESP_OKAY,   RESP_OKAY,   0, 32'hCAFEF00D,                  RESP_OKAY,   0, 5);
        tbl[8]  = mk(1, DDC_REG_1C,         32'h00000001, 2, 0, 0, 0, 0, RESP_OKAY,   RESP_DECERR, 0, VERIFY ? 32'h1 : 32'h0,        VERIFY ? RESP_DECERR : RESP_OKAY, VERIFY, VERIFY ? 7 : 5);
        tbl[9]  = mk(0, DDC_REG_18,         32'h0,        0, 0, 0, 0, 0, RESP_OKAY,   RESP_EXOKAY, 0, 32'h0,                         RESP_EXOKAY, 1, 3);
        tbl[10] = mk(1, DDC_REG_00,         32'h55AA55AA, 0, 0, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   0, VERIFY ? 32'h55AA55AA : 32'h0, RESP_OKAY,   0, VERIFY ? 5 : 3);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.awvalid",   awvalid, 0);
        check("reset.wvalid",    wvalid, 0);
        check("reset.bready",    bready, 0);
        check("reset.arvalid",   arvalid, 0);
        check("reset.rready",    rready, 0);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.rsp_err",   rsp_err, 0);
        check("reset.rsp_rdata", rsp_rdata, 0);
        check("reset.rsp_resp",  rsp_resp, 0);
        check("reset.awaddr",    awaddr, 0);
        check("reset.wdata",     wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while the write channels are waiting on a stalled slave
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = DDC_REG_10; cmd_wdata = 32'hFFFF0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst.awvalid_before", awvalid, 1);
        check("midrst.wvalid_before",  wvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.awvalid_async", awvalid, 0);
        check("midrst.wvalid_async",  wvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rst_rsp = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) rst_rsp++;
        end
        check("midrst.no_rsp",    rst_rsp, 0);
        check("midrst.cmd_ready", cmd_ready, 1);

        // Randomized commands against the reference model
        for (int i = 0; i < 40; i++) begin
            v.wr      = 1'($urandom_range(0, 1));
            v.addr    = 5'($urandom);
            v.wdata   = $urandom;
            v.aw_d    = $urandom_range(0, 3);
            v.w_d     = $urandom_range(0, 3);
            v.b_d     = $urandom_range(0, 3);
            v.ar_d    = $urandom_range(0, 3);
            v.r_d     = $urandom_range(0, 3);
            v.bresp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
            v.rresp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
            v.corrupt = ($urandom_range(0, 4) == 0);
            predict(v);
            run_cmd(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
